// File: rtl/axis_pkt_buffer.sv
// AXI-Stream circular FIFO with tdata/tlast/tuser, registered handshakes,
// occupancy/packet counters and optional store-and-forward packet gating.
module axis_pkt_buffer #(
  parameter int unsigned DW       = 8,
  parameter int unsigned UW       = 1,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PKT_MODE = 0,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  input  logic [UW-1:0] s_tuser,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [UW-1:0] m_tuser,
  output logic [CW-1:0] count,
  output logic [CW-1:0] pkt_count
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pkt_count;
  logic          r_release;
  logic          r_s_tready;
  logic          r_m_tvalid;
  beat_t         r_head;

  logic          w_push;
  logic          w_pop;
  logic          w_pkt_inc;
  logic          w_pkt_dec;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_pkt_count_nxt;
  logic          w_release_nxt;
  logic          w_m_tvalid_nxt;
  beat_t         w_in;
  beat_t         w_head;

  assign w_push    = s_tvalid & r_s_tready;
  assign w_pop     = r_m_tvalid & m_tready;
  assign w_pkt_inc = w_push & s_tlast;
  assign w_pkt_dec = w_pop & r_head.last;

  assign w_in.data = s_tdata;
  assign w_in.last = s_tlast;
  assign w_in.user = s_tuser;

  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_pkt_count_nxt = r_pkt_count;
    case ({w_pkt_inc, w_pkt_dec})
      2'b10:   w_pkt_count_nxt = r_pkt_count + CW'(1);
      2'b01:   w_pkt_count_nxt = r_pkt_count - CW'(1);
      default: w_pkt_count_nxt = r_pkt_count;
    endcase
  end

  // Release lets an oversized packet drain once the buffer fills.
  assign w_release_nxt = (r_release & ~w_pkt_dec) | (w_count_nxt == FULL_CNT);

  always_comb begin
    w_m_tvalid_nxt = 1'b0;
    if (PKT_MODE == 0) begin
      w_m_tvalid_nxt = (w_count_nxt != '0);
    end else begin
      w_m_tvalid_nxt = (w_count_nxt != '0) &&
                       ((w_pkt_count_nxt != '0) || w_release_nxt);
    end
  end

  // The new head is the incoming beat when it lands in the slot about to be read.
  always_comb begin
    w_head = r_mem[w_rd_ptr_nxt];
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head = w_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
      r_release   <= 1'b0;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_pkt_count <= w_pkt_count_nxt;
      r_release   <= (PKT_MODE != 0) ? w_release_nxt : 1'b0;
      r_s_tready  <= (w_count_nxt < FULL_CNT);
      r_m_tvalid  <= w_m_tvalid_nxt;
      if (w_count_nxt != '0) begin
        r_head <= w_head;
      end
    end
  end

  assign s_tready  = r_s_tready;
  assign m_tvalid  = r_m_tvalid;
  assign m_tdata   = r_head.data;
  assign m_tlast   = r_head.last;
  assign m_tuser   = r_head.user;
  assign count     = r_count;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// Directed bench for axis_pkt_buffer: cut-through instance u0, packet-mode instance u1.
module tb_axis_pkt_buffer;

  logic       clk;
  logic       rstn;

  logic [7:0] s0_tdata, m0_tdata;
  logic       s0_tvalid, s0_tready, s0_tlast, m0_tvalid, m0_tready, m0_tlast;
  logic [0:0] s0_tuser, m0_tuser;
  logic [2:0] c0_count, c0_pkt;

  logic [7:0] s1_tdata, m1_tdata;
  logic       s1_tvalid, s1_tready, s1_tlast, m1_tvalid, m1_tready, m1_tlast;
  logic [0:0] s1_tuser, m1_tuser;
  logic [2:0] c1_count, c1_pkt;

  int n_checks = 0;
  int n_errors = 0;

  axis_pkt_buffer #(.DW(8), .UW(1), .DEPTH(4), .PKT_MODE(0)) u0 (
    .clk(clk), .rstn(rstn),
    .s_tdata(s0_tdata), .s_tvalid(s0_tvalid), .s_tready(s0_tready),
    .s_tlast(s0_tlast), .s_tuser(s0_tuser),
    .m_tdata(m0_tdata), .m_tvalid(m0_tvalid), .m_tready(m0_tready),
    .m_tlast(m0_tlast), .m_tuser(m0_tuser),
    .count(c0_count), .pkt_count(c0_pkt)
  );

  axis_pkt_buffer #(.DW(8), .UW(1), .DEPTH(4), .PKT_MODE(1)) u1 (
    .clk(clk), .rstn(rstn),
    .s_tdata(s1_tdata), .s_tvalid(s1_tvalid), .s_tready(s1_tready),
    .s_tlast(s1_tlast), .s_tuser(s1_tuser),
    .m_tdata(m1_tdata), .m_tvalid(m1_tvalid), .m_tready(m1_tready),
    .m_tlast(m1_tlast), .m_tuser(m1_tuser),
    .count(c1_count), .pkt_count(c1_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tuser = '0; m0_tready = 1'b0;
    s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tuser = '0; m1_tready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_s_tready", 32'(s0_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m0_tvalid), 32'd0);
    chk("rst_count",    32'(c0_count),  32'd0);
    chk("rst_m_tdata",  32'(m0_tdata),  32'd0);
    chk("rst_pkt_tvalid", 32'(m1_tvalid), 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_s_tready", 32'(s0_tready), 32'd1);
    chk("post_rst_s1_tready", 32'(s1_tready), 32'd1);

    // Reset then stream
    m0_tready = 1'b1; s0_tvalid = 1'b1; s0_tdata = 8'h11; s0_tlast = 1'b0; s0_tuser = 1'b1;
    tick();
    chk("s1_valid",  32'(m0_tvalid), 32'd1);
    chk("s1_data",   32'(m0_tdata),  32'h11);
    chk("s1_user",   32'(m0_tuser),  32'd1);
    chk("s1_last",   32'(m0_tlast),  32'd0);
    chk("s1_count",  32'(c0_count),  32'd1);
    s0_tdata = 8'h22; s0_tuser = 1'b0;
    tick();
    chk("s2_data",   32'(m0_tdata),  32'h22);
    chk("s2_user",   32'(m0_tuser),  32'd0);
    chk("s2_count",  32'(c0_count),  32'd1);
    s0_tdata = 8'h33; s0_tlast = 1'b1;
    tick();
    chk("s3_data",   32'(m0_tdata),  32'h33);
    chk("s3_last",   32'(m0_tlast),  32'd1);
    chk("s3_count",  32'(c0_count),  32'd1);
    chk("s3_pkt",    32'(c0_pkt),    32'd1);
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    tick();
    chk("s4_valid",  32'(m0_tvalid), 32'd0);
    chk("s4_count",  32'(c0_count),  32'd0);
    chk("s4_pkt",    32'(c0_pkt),    32'd0);

    // Fill and backpressure
    m0_tready = 1'b0; s0_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_tdata = 8'(8'hA0 + i);
      tick();
      chk("fill_count", 32'(c0_count), 32'(i + 1));
    end
    chk("full_s_tready", 32'(s0_tready), 32'd0);
    chk("full_m_tvalid", 32'(m0_tvalid), 32'd1);
    chk("full_m_tdata",  32'(m0_tdata),  32'hA0);
    s0_tdata = 8'hA4;
    tick();
    chk("stall_count", 32'(c0_count), 32'd4);
    chk("stall_data",  32'(m0_tdata), 32'hA0);
    chk("stall_ready", 32'(s0_tready), 32'd0);
    m0_tready = 1'b1;
    tick();
    chk("drain1_data",  32'(m0_tdata),  32'hA1);
    chk("drain1_count", 32'(c0_count),  32'd3);
    chk("drain1_ready", 32'(s0_tready), 32'd1);
    tick();
    chk("drain2_data",  32'(m0_tdata), 32'hA2);
    chk("drain2_count", 32'(c0_count), 32'd3);
    s0_tdata = 8'hA5;
    tick();
    chk("drain3_data",  32'(m0_tdata), 32'hA3);
    s0_tvalid = 1'b0;
    tick();
    chk("drain4_data",  32'(m0_tdata), 32'hA4);
    chk("drain4_count", 32'(c0_count), 32'd2);
    tick();
    chk("drain5_data",  32'(m0_tdata), 32'hA5);
    tick();
    chk("drain_empty_valid", 32'(m0_tvalid), 32'd0);
    chk("drain_empty_count", 32'(c0_count),  32'd0);

    // Wrap with simultaneous push/pop
    s0_tvalid = 1'b1; m0_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s0_tdata = 8'(i);
      tick();
      chk("wrap_data",  32'(m0_tdata),  32'(i));
      chk("wrap_valid", 32'(m0_tvalid), 32'd1);
      chk("wrap_count", 32'(c0_count),  32'd1);
    end
    s0_tvalid = 1'b0;
    tick();
    chk("wrap_end_count", 32'(c0_count), 32'd0);

    // Packet mode gating
    m1_tready = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = 8'h01; s1_tlast = 1'b0;
    tick();
    s1_tvalid = 1'b0;
    chk("pg_b1_valid", 32'(m1_tvalid), 32'd0);
    chk("pg_b1_count", 32'(c1_count),  32'd1);
    repeat (2) tick();
    chk("pg_idle_valid", 32'(m1_tvalid), 32'd0);
    s1_tvalid = 1'b1; s1_tdata = 8'h02;
    tick();
    s1_tvalid = 1'b0;
    repeat (2) tick();
    chk("pg_b2_valid", 32'(m1_tvalid), 32'd0);
    chk("pg_b2_count", 32'(c1_count),  32'd2);
    s1_tvalid = 1'b1; s1_tdata = 8'h03; s1_tlast = 1'b1;
    tick();
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    chk("pg_b3_valid", 32'(m1_tvalid), 32'd1);
    chk("pg_b3_pkt",   32'(c1_pkt),    32'd1);
    chk("pg_b3_data",  32'(m1_tdata),  32'h01);
    tick();
    chk("pg_o2_data",  32'(m1_tdata),  32'h02);
    tick();
    chk("pg_o3_data",  32'(m1_tdata),  32'h03);
    chk("pg_o3_last",  32'(m1_tlast),  32'd1);
    tick();
    chk("pg_done_valid", 32'(m1_tvalid), 32'd0);
    chk("pg_done_pkt",   32'(c1_pkt),    32'd0);

    // Packet mode oversized packet
    s1_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s1_tdata = 8'(8'hB0 + i);
      tick();
      chk("ov_fill_valid", 32'(m1_tvalid), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("ov_full_count", 32'(c1_count),  32'd4);
    chk("ov_full_data",  32'(m1_tdata),  32'hB0);
    chk("ov_full_ready", 32'(s1_tready), 32'd0);
    s1_tdata = 8'hB4;
    tick();
    chk("ov_p1_valid", 32'(m1_tvalid), 32'd1);
    chk("ov_p1_data",  32'(m1_tdata),  32'hB1);
    chk("ov_p1_count", 32'(c1_count),  32'd3);
    chk("ov_p1_ready", 32'(s1_tready), 32'd1);
    tick();
    chk("ov_p2_data",  32'(m1_tdata),  32'hB2);
    chk("ov_p2_valid", 32'(m1_tvalid), 32'd1);
    s1_tdata = 8'hB5; s1_tlast = 1'b1;
    tick();
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    chk("ov_p3_data",  32'(m1_tdata),  32'hB3);
    chk("ov_p3_pkt",   32'(c1_pkt),    32'd1);
    tick();
    chk("ov_p4_data",  32'(m1_tdata),  32'hB4);
    chk("ov_p4_valid", 32'(m1_tvalid), 32'd1);
    tick();
    chk("ov_p5_data",  32'(m1_tdata),  32'hB5);
    chk("ov_p5_last",  32'(m1_tlast),  32'd1);
    chk("ov_p5_valid", 32'(m1_tvalid), 32'd1);
    tick();
    chk("ov_end_valid", 32'(m1_tvalid), 32'd0);
    chk("ov_end_count", 32'(c1_count),  32'd0);
    chk("ov_end_pkt",   32'(c1_pkt),    32'd0);
    s1_tvalid = 1'b1; s1_tdata = 8'hEE;
    tick();
    s1_tvalid = 1'b0;
    chk("ov_release_cleared", 32'(m1_tvalid), 32'd0);
    chk("ov_release_count",   32'(c1_count),  32'd1);

    // Asynchronous reset mid-operation
    m0_tready = 1'b0; s0_tvalid = 1'b1; s0_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s0_tdata = 8'(8'hC0 + i);
      tick();
    end
    s0_tvalid = 1'b0;
    chk("ar_pre_count", 32'(c0_count),  32'd3);
    chk("ar_pre_valid", 32'(m0_tvalid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid",  32'(m0_tvalid), 32'd0);
    chk("ar_ready",  32'(s0_tready), 32'd0);
    chk("ar_count",  32'(c0_count),  32'd0);
    chk("ar_pkt",    32'(c0_pkt),    32'd0);
    chk("ar_data",   32'(m0_tdata),  32'd0);
    chk("ar_u1_count", 32'(c1_count), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("ar_rel_ready", 32'(s0_tready), 32'd1);
    m0_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_empty_valid", 32'(m0_tvalid), 32'd0);
      chk("ar_empty_data",  32'(m0_tdata),  32'd0);
    end
    s0_tvalid = 1'b1; s0_tdata = 8'hD0;
    tick();
    s0_tvalid = 1'b0;
    chk("ar_new_data",  32'(m0_tdata),  32'hD0);
    chk("ar_new_count", 32'(c0_count),  32'd1);
    tick();
    chk("ar_final_valid", 32'(m0_tvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
